// File: rtl/ex_result_stage.sv
// ex_result_stage: EX-stage result/branch resolution with a valid/ready output buffer.
// Each accepted operation is captured as {br_taken, br_target, result}.
// Macro EX_RESULT_SKID_EN selects a 2-entry skid FIFO with registered in_ready.
// When the macro is undefined, the buffer is a single output register with
// combinational in_ready.
module ex_result_stage #(
   parameter int unsigned OPERAND_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPERAND_WIDTH-1:0] alu_out,
   input  logic [OPERAND_WIDTH-1:0] btr_out,
   input  logic                     seq,
   input  logic                     slt,
   input  logic                     sle,
   input  logic                     sco,
   input  logic                     beqz,
   input  logic                     bnez,
   input  logic                     bltz,
   input  logic                     bgez,
   input  logic [2:0]               res_sel,
   input  logic [2:0]               br_type,
   input  logic [OPERAND_WIDTH-1:0] pc_plus2,
   input  logic [OPERAND_WIDTH-1:0] br_offset,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPERAND_WIDTH-1:0] out_result,
   output logic                     br_taken,
   output logic [OPERAND_WIDTH-1:0] br_target,
   output logic [1:0]               occupancy
);

   localparam int unsigned EntryW = 2 * OPERAND_WIDTH + 1;

   logic [OPERAND_WIDTH-1:0] w_result;
   logic                     w_taken;
   logic [OPERAND_WIDTH-1:0] w_target;
   logic [EntryW-1:0]        w_entry;

   // Result select and branch condition decode for the incoming operation
   always_comb begin
      w_result = '0;
      w_taken  = 1'b0;
      case (res_sel)
         3'd0:    w_result = alu_out;
         3'd1:    w_result = btr_out;
         3'd2:    w_result = {{(OPERAND_WIDTH-1){1'b0}}, seq};
         3'd3:    w_result = {{(OPERAND_WIDTH-1){1'b0}}, slt};
         3'd4:    w_result = {{(OPERAND_WIDTH-1){1'b0}}, sle};
         3'd5:    w_result = {{(OPERAND_WIDTH-1){1'b0}}, sco};
         3'd6:    w_result = pc_plus2;
         default: w_result = '0;
      endcase
      case (br_type)
         3'd1:    w_taken = beqz;
         3'd2:    w_taken = bnez;
         3'd3:    w_taken = bltz;
         3'd4:    w_taken = bgez;
         3'd5:    w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
      // Sum wraps modulo 2^OPERAND_WIDTH by truncation
      w_target = w_taken ? (pc_plus2 + br_offset) : pc_plus2;
      w_entry  = {w_taken, w_target, w_result};
   end

`ifdef EX_RESULT_SKID_EN

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic              r_in_ready;
   logic [EntryW-1:0] r_head;
   logic [EntryW-1:0] r_tail;
   logic              w_accept;
   logic              w_deliver;
   logic              w_load_head;
   logic              w_load_tail;
   logic              w_head_from_tail;

   assign w_accept  = in_valid & r_in_ready;
   assign w_deliver = (r_state != StEmpty) & out_ready;

   // Next-state and entry load decode; flush wins over any handshake
   always_comb begin
      w_state_next     = r_state;
      w_load_head      = 1'b0;
      w_load_tail      = 1'b0;
      w_head_from_tail = 1'b0;
      if (flush) begin
         w_state_next = StEmpty;
      end else begin
         case (r_state)
            StEmpty: begin
               if (w_accept) begin
                  w_load_head  = 1'b1;
                  w_state_next = StOne;
               end
            end
            StOne: begin
               if (w_accept && w_deliver) begin
                  w_load_head = 1'b1;
               end else if (w_accept) begin
                  w_load_tail  = 1'b1;
                  w_state_next = StTwo;
               end else if (w_deliver) begin
                  w_state_next = StEmpty;
               end
            end
            StTwo: begin
               // in_ready is low here, so only a deliver can happen
               if (w_deliver) begin
                  w_head_from_tail = 1'b1;
                  w_state_next     = StOne;
               end
            end
            default: w_state_next = StEmpty;
         endcase
      end
   end

   // State register; in_ready is precomputed from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StEmpty;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next != StTwo);
      end
   end

   // Entry storage; head drives the outputs and only moves on a handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_load_head) begin
            r_head <= w_entry;
         end else if (w_head_from_tail) begin
            r_head <= r_tail;
         end
         if (w_load_tail) begin
            r_tail <= w_entry;
         end
      end
   end

   // Output mapping from state and head entry
   always_comb begin
      in_ready   = r_in_ready;
      out_valid  = (r_state != StEmpty);
      out_result = r_head[OPERAND_WIDTH-1:0];
      br_target  = r_head[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
      br_taken   = r_head[EntryW-1];
      case (r_state)
         StOne:   occupancy = 2'd1;
         StTwo:   occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

`else

   logic              r_valid;
   logic [EntryW-1:0] r_entry;
   logic              w_accept;
   logic              w_deliver;

   assign w_deliver = r_valid & out_ready;
   assign w_accept  = in_valid & in_ready;

   // Single output register; flush drops both the held and the incoming op
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_entry <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_entry <= w_entry;
      end else if (w_deliver) begin
         r_valid <= 1'b0;
      end
   end

   // Output mapping; in_ready passes out_ready through when full
   always_comb begin
      in_ready   = !r_valid || out_ready;
      out_valid  = r_valid;
      out_result = r_entry[OPERAND_WIDTH-1:0];
      br_target  = r_entry[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
      br_taken   = r_entry[EntryW-1];
      occupancy  = {1'b0, r_valid};
   end

`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: directed self-checking bench for ex_result_stage.
// Expectations that depend on the buffer depth follow EX_RESULT_SKID_EN.
module tb_ex_result_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] alu_out;
   logic [15:0] btr_out;
   logic        seq, slt, sle, sco;
   logic        beqz, bnez, bltz, bgez;
   logic [2:0]  res_sel;
   logic [2:0]  br_type;
   logic [15:0] pc_plus2;
   logic [15:0] br_offset;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        br_taken;
   logic [15:0] br_target;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   ex_result_stage #(
      .OPERAND_WIDTH(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_out    (alu_out),
      .btr_out    (btr_out),
      .seq        (seq),
      .slt        (slt),
      .sle        (sle),
      .sco        (sco),
      .beqz       (beqz),
      .bnez       (bnez),
      .bltz       (bltz),
      .bgez       (bgez),
      .res_sel    (res_sel),
      .br_type    (br_type),
      .pc_plus2   (pc_plus2),
      .br_offset  (br_offset),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .occupancy  (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; samples are taken 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".occupancy"}, {30'd0, occupancy}, 32'd0);
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, ".out_result"}, {16'd0, out_result}, 32'd0);
      check({tag, ".br_taken"}, {31'd0, br_taken}, 32'd0);
      check({tag, ".br_target"}, {16'd0, br_target}, 32'd0);
   endtask

   // Drive one ALU-result op with an always-taken branch so entries carry payload
   task automatic drive_op(input logic [15:0] v);
      in_valid  = 1'b1;
      res_sel   = 3'd0;
      alu_out   = v;
      br_type   = 3'd5;
      pc_plus2  = 16'h0100;
      br_offset = 16'h0020;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      alu_out = 16'h0; btr_out = 16'h0; res_sel = 3'd0; br_type = 3'd0;
      seq = 1'b0; slt = 1'b0; sle = 1'b0; sco = 1'b0;
      beqz = 1'b0; bnez = 1'b0; bltz = 1'b0; bgez = 1'b0;
      pc_plus2 = 16'h0; br_offset = 16'h0;
      step();
      step();
      rst = 1'b0;
      check_reset_outputs("reset");

      // slt select, visible one cycle after accept
      in_valid = 1'b1; res_sel = 3'd3; slt = 1'b1; alu_out = 16'h1234;
      br_type = 3'd0; pc_plus2 = 16'h0100; br_offset = 16'h0010;
      step();
      in_valid = 1'b0; slt = 1'b0;
      check("slt.out_valid", {31'd0, out_valid}, 32'd1);
      check("slt.out_result", {16'd0, out_result}, 32'h0001);
      check("slt.br_taken", {31'd0, br_taken}, 32'd0);
      check("slt.br_target", {16'd0, br_target}, 32'h0100);
      step();
      check("slt.drained", {31'd0, out_valid}, 32'd0);

      // Remaining result selects
      in_valid = 1'b1; res_sel = 3'd0; alu_out = 16'hA5A5; btr_out = 16'h3C3C;
      step();
      check("sel0.alu", {16'd0, out_result}, 32'hA5A5);
      res_sel = 3'd1;
      step();
      check("sel1.btr", {16'd0, out_result}, 32'h3C3C);
      res_sel = 3'd6; pc_plus2 = 16'h4242;
      step();
      check("sel6.pc", {16'd0, out_result}, 32'h4242);
      res_sel = 3'd5; sco = 1'b1;
      step();
      check("sel5.sco", {16'd0, out_result}, 32'h0001);
      res_sel = 3'd7; seq = 1'b1; sle = 1'b1;
      step();
      check("sel7.zero", {16'd0, out_result}, 32'h0000);
      seq = 1'b0; sle = 1'b0; sco = 1'b0;

      // Branch resolution, including the modular wrap
      res_sel = 3'd0; br_type = 3'd1; beqz = 1'b1;
      pc_plus2 = 16'hFFFE; br_offset = 16'h0004;
      step();
      check("beqz.taken", {31'd0, br_taken}, 32'd1);
      check("beqz.wrap", {16'd0, br_target}, 32'h0002);
      br_type = 3'd2; bnez = 1'b0;
      step();
      check("bnez.not_taken", {31'd0, br_taken}, 32'd0);
      check("bnez.target", {16'd0, br_target}, 32'hFFFE);
      br_type = 3'd4; bgez = 1'b1; pc_plus2 = 16'h1000; br_offset = 16'hFFF0;
      step();
      check("bgez.taken", {31'd0, br_taken}, 32'd1);
      check("bgez.target", {16'd0, br_target}, 32'h0FF0);
      br_type = 3'd6; bltz = 1'b1; bnez = 1'b1;
      step();
      check("type6.never", {31'd0, br_taken}, 32'd0);
      check("type6.target", {16'd0, br_target}, 32'h1000);
      beqz = 1'b0; bnez = 1'b0; bltz = 1'b0; bgez = 1'b0;
      in_valid = 1'b0;
      step();
      check("branch.drained", {31'd0, out_valid}, 32'd0);

      // Stall with three back-to-back ops A, B, C
      out_ready = 1'b0;
      drive_op(16'h000A);
      step();
      drive_op(16'h000B);
      step();
      drive_op(16'h000C);
      step();
      in_valid = 1'b0;
      check("stall.head", {16'd0, out_result}, 32'h000A);
      check("stall.in_ready", {31'd0, in_ready}, 32'd0);
      check("stall.taken", {31'd0, br_taken}, 32'd1);
      check("stall.target", {16'd0, br_target}, 32'h0120);
`ifdef EX_RESULT_SKID_EN
      check("stall.occupancy", {30'd0, occupancy}, 32'd2);
      step();
      check("stall.hold", {16'd0, out_result}, 32'h000A);
      out_ready = 1'b1;
      step();
      check("stall.second", {16'd0, out_result}, 32'h000B);
      check("stall.second_valid", {31'd0, out_valid}, 32'd1);
      check("stall.occ_one", {30'd0, occupancy}, 32'd1);
      step();
      check("stall.no_c", {31'd0, out_valid}, 32'd0);
`else
      check("stall.occupancy", {30'd0, occupancy}, 32'd1);
      step();
      check("stall.hold", {16'd0, out_result}, 32'h000A);
      out_ready = 1'b1;
      #1;
      check("stall.in_ready_pass", {31'd0, in_ready}, 32'd1);
      step();
      check("stall.no_b", {31'd0, out_valid}, 32'd0);
`endif

      // Flush while full with a same-cycle incoming op
      out_ready = 1'b0;
      drive_op(16'h0011);
      step();
`ifdef EX_RESULT_SKID_EN
      drive_op(16'h0022);
      step();
      check("flush.pre_occ", {30'd0, occupancy}, 32'd2);
`endif
      drive_op(16'h0033);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush.out_valid", {31'd0, out_valid}, 32'd0);
      check("flush.occupancy", {30'd0, occupancy}, 32'd0);
      check("flush.in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("flush.dropped", {31'd0, out_valid}, 32'd0);

      // Reset while stalled and full
      drive_op(16'h0044);
      step();
`ifdef EX_RESULT_SKID_EN
      drive_op(16'h0055);
      step();
      check("rst.pre_occ", {30'd0, occupancy}, 32'd2);
`endif
      check("rst.pre_valid", {31'd0, out_valid}, 32'd1);
      drive_op(16'h0066);
      rst = 1'b1;
      flush = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      check_reset_outputs("rst_stall");

      // Continuous streaming
      out_ready = 1'b1;
      drive_op(16'h0100);
      step();
      for (int i = 1; i < 5; i++) begin
         drive_op(16'h0100 + 16'(i));
         step();
         check("stream.valid", {31'd0, out_valid}, 32'd1);
         check("stream.occ", {30'd0, occupancy}, 32'd1);
         check("stream.in_ready", {31'd0, in_ready}, 32'd1);
         check("stream.data", {16'd0, out_result}, 32'h0100 + 32'(i));
      end
      in_valid = 1'b0;
      step();
      check("stream.drained", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 The module SHALL have parameter OPERAND_WIDTH, default 16, giving the datapath width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the upstream ALU stage presents a valid operation.
REQ-005 The module SHALL have port in_ready, output, 1 bit: this stage accepts an operation this cycle.
REQ-006 The module SHALL have port alu_out, input, OPERAND_WIDTH: the ALU result.
REQ-007 The module SHALL have port btr_out, input, OPERAND_WIDTH: the bit-reversed operand.
REQ-008 The module SHALL have ports seq, slt, sle, sco, input, 1 bit each: the ALU set-condition flags.
REQ-009 The module SHALL have ports beqz, bnez, bltz, bgez, input, 1 bit each: the ALU branch-condition flags.
REQ-010 The module SHALL have port res_sel, input, 3 bits: the result select.
REQ-011 The module SHALL have port br_type, input, 3 bits: the branch type.
REQ-012 The module SHALL have port pc_plus2, input, OPERAND_WIDTH: the sequential PC.
REQ-013 The module SHALL have port br_offset, input, OPERAND_WIDTH: the sign-extended branch displacement.
REQ-014 The module SHALL have port flush, input, 1 bit: discard all held operations.
REQ-015 The module SHALL have port out_valid, output, 1 bit: the downstream payload is valid.
REQ-016 The module SHALL have port out_ready, input, 1 bit: downstream accepts the payload.
REQ-017 The module SHALL have port out_result, output, OPERAND_WIDTH: the selected writeback value.
REQ-018 The module SHALL have port br_taken, output, 1 bit: the branch resolved taken.
REQ-019 The module SHALL have port br_target, output, OPERAND_WIDTH: the resolved next PC.
REQ-020 The module SHALL have port occupancy, output, 2 bits: the number of held entries.

Function
REQ-021 The module SHALL accept an operation when in_valid and in_ready are both high at a clock edge.
REQ-022 The module SHALL deliver the head entry when out_valid and out_ready are both high at a clock edge.
REQ-023 The module SHALL compute the result on accept from res_sel: 0 alu_out; 1 btr_out; 2..5 zero-extended seq/slt/sle/sco; 6 pc_plus2; 7 all zeros.
REQ-024 The module SHALL compute br_taken on accept from br_type: 0 never; 1 beqz; 2 bnez; 3 bltz; 4 bgez; 5 always; 6..7 never.
REQ-025 The module SHALL set br_target to pc_plus2+br_offset modulo 2^OPERAND_WIDTH when taken, and to pc_plus2 otherwise.
REQ-026 The module SHALL hold entries in a 2-entry skid FIFO with states EMPTY, ONE and TWO; the head drives out_*, and out_valid SHALL be high whenever the state is not EMPTY.
REQ-027 The module SHALL drive in_ready as a registered signal, high exactly when the state is not TWO.
REQ-028 Transitions SHALL be: accept only, occupancy +1; deliver only, occupancy -1; accept and deliver together, occupancy unchanged with the new entry queued behind the head.
REQ-029 In state TWO with out_ready low, the module SHALL hold entries unchanged and accept nothing.
REQ-030 The module SHALL keep entry order strictly FIFO, so no entry is lost or duplicated under any in_valid/out_ready pattern.
REQ-031 On flush, the module SHALL go to EMPTY at the next edge and drop any same-cycle accept; flush SHALL take priority over accept and deliver.
REQ-032 The module SHALL hold payload outputs stable while out_valid is high and out_ready is low.

Reset
REQ-033 With rst high at an edge, the module SHALL set the state to EMPTY, occupancy to 0, out_valid to 0, in_ready to 1, and out_result, br_taken and br_target to 0.
REQ-034 Reset SHALL override flush and any in-flight handshake, including reset mid-stall in state TWO.

Configuration
REQ-035 The module SHALL compile the 2-entry skid FIFO when macro EX_RESULT_SKID_EN is defined.
REQ-036 Without EX_RESULT_SKID_EN, the module SHALL use a single output register with combinational in_ready = !out_valid || out_ready; occupancy SHALL never exceed 1, and all other requirements SHALL still apply.

Verification
REQ-037 The bench SHALL cover: res_sel=3, slt=1, out_ready=1 -> out_result=16'h0001 and out_valid high one cycle after accept.
REQ-038 The bench SHALL cover: br_type=1, beqz=1, pc_plus2=16'hFFFE, br_offset=16'h0004 -> br_taken=1, br_target=16'h0002 (wrap-around).
REQ-039 The bench SHALL cover: out_ready=0 with three back-to-back in_valid (A, B, C) -> A and B held, occupancy=2, in_ready=0, C not accepted; then out_ready=1 -> A, B delivered in order.
REQ-040 The bench SHALL cover: flush asserted in state TWO with in_valid=1 the same cycle -> next cycle out_valid=0, occupancy=0, in_ready=1, incoming entry dropped.
REQ-041 The bench SHALL cover: rst asserted while in state TWO -> all outputs at reset values next cycle.
REQ-042 The bench SHALL cover: continuous in_valid=1, out_ready=1 -> one result per cycle, occupancy steady at 1.
